// File: rtl/aoc_bits_pkg.sv
// Shared constants, FSM encoding and nibble helpers for the bit-serial literal decoders.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package aoc_bits_pkg;

    localparam int NIBBLE_W    = 4;
    localparam int MAX_NIBBLES = 16;
    localparam int GROUP_BITS  = 5;
    localparam int NUMBER_W    = NIBBLE_W * MAX_NIBBLES;
    localparam int COUNT_W     = 7;

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    // Collector FSM encoding, kept as plain constants so older blocks can share it.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PREFIX = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Write a nibble into slot 'slot' of a left-aligned number (slot 0 is the top nibble).
    function automatic logic [NUMBER_W-1:0] insertNibble(
        input logic [NUMBER_W-1:0] number,
        input logic [3:0]          slot,
        input logic [NIBBLE_W-1:0] nibble
    );
        logic [NUMBER_W-1:0] result;
        result = number;
        for (int k = 0; k < MAX_NIBBLES; k++) begin
            if (slot == k[3:0]) begin
                result[NUMBER_W-1-NIBBLE_W*k -: NIBBLE_W] = nibble;
            end
        end
        return result;
    endfunction

    // Increment that sticks at the counter's maximum instead of wrapping.
    function automatic logic [COUNT_W-1:0] satInc(input logic [COUNT_W-1:0] value);
        return (value == COUNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/literal_collector_if.sv
// Handshake and result bundle between a bit-stream source and the literal collector.
// Latency: n/a (wires only).
// Backpressure: bitReady gates each bitValid/bitIn transfer.
interface literal_collector_if;
    import aoc_bits_pkg::*;

    logic                  start;
    logic                  bitValid;
    logic                  bitIn;
    logic                  bitReady;
    logic                  busy;
    logic                  enable;
    logic [NUMBER_W-1:0]   inputNumber;
    logic [MAX_NIBBLES:0]  validNibbles;
    logic [COUNT_W-1:0]    bitsConsumed;
    logic                  overflow;

    // Stream source / consumer of the collected literal.
    modport master (
        output start, bitValid, bitIn,
        input  bitReady, busy, enable, inputNumber, validNibbles, bitsConsumed, overflow
    );

    // The collector itself.
    modport slave (
        input  start, bitValid, bitIn,
        output bitReady, busy, enable, inputNumber, validNibbles, bitsConsumed, overflow
    );

endinterface

// File: rtl/literal_collector.sv
// Collects a 5-bit-grouped literal (continue flag + nibble) from a serial stream into a left-aligned number.
// Latency: enable pulses the cycle after the final data-bit transfer.
// Backpressure: bitReady only in PREFIX/DATA; bitValid low stalls every register.
module literal_collector
    import aoc_bits_pkg::*;
(
    input  logic                clk,
    input  logic                resetB,
    literal_collector_if.slave  bus
);

    logic [1:0]            state;
    logic [GROUP_BITS-1:0] groupIdx;
    logic [1:0]            dataCnt;
    logic [NIBBLE_W-2:0]   nibbleReg;
    logic                  lastGroup;
    logic [NUMBER_W-1:0]   inputNumber;
    logic [MAX_NIBBLES:0]  validNibbles;
    logic [COUNT_W-1:0]    bitsConsumed;
    logic                  overflow;

    logic                  bitReady;
    logic                  transfer;
    logic                  startAccept;
    logic                  prefixXfer;
    logic                  dataXfer;
    logic                  nibbleDone;
    logic                  groupsFull;
    logic [NIBBLE_W-1:0]   nibbleNext;

    assign bitReady    = (state == ST_PREFIX) || (state == ST_DATA);
    assign transfer    = bus.bitValid && bitReady;
    assign startAccept = (state == ST_IDLE) && bus.start;
    assign prefixXfer  = transfer && (state == ST_PREFIX);
    assign dataXfer    = transfer && (state == ST_DATA);
    assign nibbleDone  = dataXfer && (dataCnt == 2'd3);
    assign groupsFull  = (groupIdx >= GROUP_BITS'(MAX_NIBBLES));
    // Earlier three data bits sit MSB-first in nibbleReg; the current bit completes the nibble.
    assign nibbleNext  = {nibbleReg, bus.bitIn};

    // Control FSM: advances only on accepted start or on a bit transfer.
    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (startAccept) state <= ST_PREFIX;
                ST_PREFIX: if (prefixXfer)  state <= ST_DATA;
                ST_DATA:   if (nibbleDone)  state <= lastGroup ? ST_DONE : ST_PREFIX;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Group bookkeeping: continue flag, data-bit position, partial nibble and saturating group index.
    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            groupIdx  <= '0;
            dataCnt   <= '0;
            nibbleReg <= '0;
            lastGroup <= 1'b0;
        end else if (startAccept) begin
            groupIdx  <= '0;
            dataCnt   <= '0;
            nibbleReg <= '0;
            lastGroup <= 1'b0;
        end else if (prefixXfer) begin
            // A zero prefix bit marks the final group of the literal.
            lastGroup <= ~bus.bitIn;
            dataCnt   <= '0;
        end else if (dataXfer) begin
            dataCnt   <= dataCnt + 2'd1;
            nibbleReg <= nibbleNext[NIBBLE_W-2:0];
            if (nibbleDone && !groupsFull) begin
                groupIdx <= groupIdx + 1'b1;
            end
        end
    end

    // Result registers: cleared by an accepted start, otherwise held so downstream can sample after DONE.
    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            inputNumber  <= '0;
            validNibbles <= '0;
            overflow     <= 1'b0;
        end else if (startAccept) begin
            inputNumber  <= '0;
            validNibbles <= '0;
            overflow     <= 1'b0;
        end else if (nibbleDone) begin
            if (groupsFull) begin
                // Beyond sixteen groups the nibble has no slot: drop it and flag the excess.
                validNibbles[MAX_NIBBLES] <= 1'b1;
                overflow                  <= 1'b1;
            end else begin
                inputNumber                 <= insertNibble(inputNumber, groupIdx[3:0], nibbleNext);
                validNibbles[groupIdx[3:0]] <= 1'b1;
            end
        end
    end

    // Stream bit counter covering prefix and data bits; sticks at its maximum on very long literals.
    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            bitsConsumed <= '0;
        end else if (startAccept) begin
            bitsConsumed <= '0;
        end else if (transfer) begin
            bitsConsumed <= satInc(bitsConsumed);
        end
    end

    assign bus.bitReady     = bitReady;
    assign bus.busy         = (state != ST_IDLE);
    assign bus.enable       = (state == ST_DONE);
    assign bus.inputNumber  = inputNumber;
    assign bus.validNibbles = validNibbles;
    assign bus.bitsConsumed = bitsConsumed;
    assign bus.overflow     = overflow;

endmodule

// File: tb/tb_literal_collector.sv
// Directed bench for literal_collector: group-parsing model checked at every enable, plus hand values.
// Latency: checks enable lands one cycle after the last data bit.
// Backpressure: exercises bitValid gaps and ignored start pulses while busy.
module tb_literal_collector;
    import aoc_bits_pkg::*;

    logic clk = 1'b0;
    logic resetB;
    always #5 clk = ~clk;

    literal_collector_if lcIf();

    literal_collector dut (
        .clk    (clk),
        .resetB (resetB),
        .bus    (lcIf)
    );

    int   total    = 0;
    int   bad      = 0;
    int   cycle    = 0;
    int   lastXfer = -10;
    int   enCount  = 0;
    logic noisyStart = 1'b0;

    // Model expectations for the literal currently in flight.
    logic [63:0] mNum;
    logic [16:0] mMask;
    logic [6:0]  mBits;
    logic        mOvf;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Parse the bit string group by group: prefix bit, then four data bits MSB-first.
    function automatic void model(input string s);
        int pos;
        int g;
        logic last;
        logic [3:0] nib;
        pos = 0;
        g = 0;
        mNum = '0;
        mMask = '0;
        mOvf = 1'b0;
        last = 1'b0;
        while (!last && pos + 5 <= s.len()) begin
            last = (s[pos] == "0");
            pos++;
            nib = '0;
            for (int j = 0; j < 4; j++) begin
                nib = {nib[2:0], (s[pos] == "1")};
                pos++;
            end
            if (g < 16) begin
                mNum[63-4*g -: 4] = nib;
                mMask[g] = 1'b1;
            end else begin
                mMask[16] = 1'b1;
                mOvf = 1'b1;
            end
            g++;
        end
        mBits = (pos > 127) ? 7'd127 : 7'(pos);
    endfunction

    // Compare process: transfers are decided by values held across the upcoming rising edge.
    always @(negedge clk) begin
        if (lcIf.enable) begin
            enCount++;
            chk("latency", 64'(cycle), 64'(lastXfer + 1));
            chk("model inputNumber", lcIf.inputNumber, mNum);
            chk("model validNibbles", 64'(lcIf.validNibbles), 64'(mMask));
            chk("model bitsConsumed", 64'(lcIf.bitsConsumed), 64'(mBits));
            chk("model overflow", 64'(lcIf.overflow), 64'(mOvf));
        end
        if (lcIf.bitValid && lcIf.bitReady) lastXfer = cycle;
    end

    task automatic noisy();
        lcIf.start = noisyStart ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic doStart();
        lcIf.start = 1'b1;
        @(posedge clk); #1;
        lcIf.start = 1'b0;
    endtask

    task automatic sendBit(input logic b, input int gaps);
        int n;
        for (int i = 0; i < gaps; i++) begin
            lcIf.bitValid = 1'b0;
            noisy();
            @(posedge clk); #1;
        end
        lcIf.bitValid = 1'b1;
        lcIf.bitIn = b;
        noisy();
        n = 0;
        while (!lcIf.bitReady && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!lcIf.bitReady) begin
            total++;
            bad++;
            $display("FAIL readyTimeout: actual=0 required=1");
        end
        @(posedge clk); #1;
        lcIf.bitValid = 1'b0;
        lcIf.start = 1'b0;
    endtask

    task automatic runLiteral(input string tag, input string s, input int maxGap,
                              input logic [63:0] hNum, input logic [16:0] hMask,
                              input logic [6:0] hBits, input logic hOvf);
        int n;
        model(s);
        chk({tag, " modelPin"}, mNum, hNum);
        enCount = 0;
        doStart();
        for (int i = 0; i < s.len(); i++) begin
            sendBit(s[i] == "1", (maxGap > 0) ? $urandom_range(0, maxGap) : 0);
        end
        n = 0;
        while (lcIf.busy && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " idleAfterDone"}, 64'(lcIf.busy), 64'(0));
        chk({tag, " enableCount"}, 64'(enCount), 64'(1));
        chk({tag, " inputNumber"}, lcIf.inputNumber, hNum);
        chk({tag, " validNibbles"}, 64'(lcIf.validNibbles), 64'(hMask));
        chk({tag, " bitsConsumed"}, 64'(lcIf.bitsConsumed), 64'(hBits));
        chk({tag, " overflow"}, 64'(lcIf.overflow), 64'(hOvf));
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk({tag, " holdNumber"}, lcIf.inputNumber, hNum);
        chk({tag, " holdBits"}, 64'(lcIf.bitsConsumed), 64'(hBits));
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, " bitReady"}, 64'(lcIf.bitReady), 64'(0));
        chk({tag, " busy"}, 64'(lcIf.busy), 64'(0));
        chk({tag, " enable"}, 64'(lcIf.enable), 64'(0));
        chk({tag, " inputNumber"}, lcIf.inputNumber, 64'(0));
        chk({tag, " validNibbles"}, 64'(lcIf.validNibbles), 64'(0));
        chk({tag, " bitsConsumed"}, 64'(lcIf.bitsConsumed), 64'(0));
        chk({tag, " overflow"}, 64'(lcIf.overflow), 64'(0));
    endtask

    localparam string S_BASIC = "101111111000101";

    initial begin
        string s;
        resetB = 1'b0;
        lcIf.start = 1'b0;
        lcIf.bitValid = 1'b0;
        lcIf.bitIn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chkAllZero("reset");
        resetB = 1'b1;
        @(posedge clk); #1;

        runLiteral("basic", S_BASIC, 0, 64'h7E50_0000_0000_0000, 17'h00007, 7'd15, 1'b0);
        runLiteral("single", "01010", 0, 64'hA000_0000_0000_0000, 17'h00001, 7'd5, 1'b0);

        s = "";
        for (int i = 0; i < 15; i++) s = {s, "11111"};
        s = {s, "01111"};
        runLiteral("full16", s, 0, 64'hFFFF_FFFF_FFFF_FFFF, 17'h0FFFF, 7'd80, 1'b0);

        s = "";
        for (int i = 0; i < 16; i++) s = {s, "10001"};
        s = {s, "00010"};
        runLiteral("over17", s, 0, 64'h1111_1111_1111_1111, 17'h1FFFF, 7'd85, 1'b1);

        s = "";
        for (int i = 0; i < 25; i++) s = {s, "10011"};
        s = {s, "00101"};
        runLiteral("satCount", s, 0, 64'h3333_3333_3333_3333, 17'h1FFFF, 7'd127, 1'b1);

        noisyStart = 1'b1;
        runLiteral("gapsStarts", S_BASIC, 3, 64'h7E50_0000_0000_0000, 17'h00007, 7'd15, 1'b0);
        noisyStart = 1'b0;

        // Reset in the middle of a literal, then confirm nothing moves without a start.
        model(S_BASIC);
        doStart();
        for (int i = 0; i < 7; i++) sendBit(S_BASIC[i] == "1", 0);
        chk("midReset preBits", 64'(lcIf.bitsConsumed), 64'(7));
        #2;
        resetB = 1'b0;
        #1;
        chkAllZero("midReset");
        @(posedge clk); #1;
        resetB = 1'b1;
        lcIf.bitValid = 1'b1;
        lcIf.bitIn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("noStart bitsConsumed", 64'(lcIf.bitsConsumed), 64'(0));
        chk("noStart busy", 64'(lcIf.busy), 64'(0));
        lcIf.bitValid = 1'b0;
        @(posedge clk); #1;
        runLiteral("afterReset", S_BASIC, 0, 64'h7E50_0000_0000_0000, 17'h00007, 7'd15, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/literal_collector.md
LITERAL_COLLECTOR -- requirements
Module: literal_collector

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk, resetB.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetB  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request to begin collecting a literal; the first bit is presented on the following cycles.
REQ-005 bitValid  input  1  bitIn carries a valid stream bit.
REQ-006 bitIn  input  1  serial packet bit, MSB-first stream order.
REQ-007 bitReady  output  1  the block accepts bitIn this cycle; a transfer occurs when bitValid and bitReady are both high.
REQ-008 busy  output  1  collection in progress (any state other than IDLE).
REQ-009 enable  output  1  one-cycle pulse: literal complete, downstream number register SHALL load.
REQ-010 inputNumber  output  64  collected nibbles, left-aligned: nibble k in bits [63-4k:60-4k].
REQ-011 validNibbles  output  17  thermometer mask: bit k set once nibble k is collected; bit 16 flags a 17th group.
REQ-012 bitsConsumed  output  7  stream bits accepted for this literal, saturating at 127.
REQ-013 overflow  output  1  sticky: the literal had more than 16 groups.

Function
REQ-014 States SHALL be IDLE, PREFIX, DATA, DONE; bitReady SHALL be high only in PREFIX and DATA.
REQ-015 IDLE: start=1 SHALL clear inputNumber, validNibbles, bitsConsumed, overflow and the group index, then enter PREFIX; start SHALL be ignored in every other state.
REQ-016 PREFIX: on transfer, lastGroup SHALL be latched as ~bitIn, bitsConsumed SHALL increment, and the state SHALL go to DATA with the data-bit count at 0.
REQ-017 DATA: each transfer SHALL shift bitIn into a 4-bit nibble register (MSB first) and increment bitsConsumed.
REQ-018 On the 4th DATA transfer with group index g<16: nibble SHALL be written to slot g of inputNumber and validNibbles[g] SHALL be set, both visible the next cycle.
REQ-019 On the 4th DATA transfer with g>=16: nibble SHALL be discarded, and validNibbles[16] and overflow SHALL be set; collection SHALL continue until the last group.
REQ-020 After the 4th DATA transfer: the group index SHALL increment, saturating at 16; the state SHALL go to DONE if lastGroup, else PREFIX.
REQ-021 DONE: enable SHALL be high for exactly that one cycle; the state SHALL then return to IDLE.
REQ-022 Latency: enable SHALL assert the cycle after the final data-bit transfer.
REQ-023 bitValid low SHALL stall all state with no counter change; stalls of any length SHALL leave results identical.
REQ-024 inputNumber, validNibbles, bitsConsumed and overflow SHALL hold stable from DONE until the next accepted start.
REQ-025 bitsConsumed SHALL saturate at 127, not wrap.

Reset
REQ-026 resetB low SHALL force IDLE immediately, including mid-literal, and SHALL clear all outputs: bitReady=0, busy=0, enable=0, inputNumber=0, validNibbles=0, bitsConsumed=0, overflow=0.
REQ-027 After reset release, no transfer SHALL occur before an accepted start.

Structure
REQ-028 The shared package aoc_bits_pkg SHALL hold NIBBLE_W=4, MAX_NIBBLES=16, GROUP_BITS=5 and the state encoding.
REQ-029 The block SHALL be a single module with no sub-module; nibble slot write, counters and FSM are local.

Verification
REQ-030 start, then stream 101111111000101 with no gaps -> inputNumber=64'h7E50_0000_0000_0000, validNibbles=17'h00007, bitsConsumed=15, enable pulses one cycle after bit 15.
REQ-031 start, then stream 01010 -> inputNumber=64'hA000_0000_0000_0000, validNibbles=17'h00001, bitsConsumed=5, overflow=0.
REQ-032 Fifteen groups of 11111 then 01111 -> inputNumber=64'hFFFF_FFFF_FFFF_FFFF, validNibbles=17'h0FFFF, bitsConsumed=80, overflow=0.
REQ-033 Sixteen groups of 10001 then 00010 -> validNibbles=17'h1FFFF, overflow=1, bitsConsumed=85, inputNumber=64'h1111_1111_1111_1111 (17th nibble dropped).
REQ-034 Repeat REQ-030 with random bitValid gaps, plus start pulses while busy -> identical results, and the extra starts are ignored.
REQ-035 resetB low after 7 bits of REQ-030 -> all outputs 0, busy=0, bitReady=0; a fresh start then reproduces the REQ-030 result.
